// File: rtl/uart_rx.sv
`timescale 1ns/1ps
// uart_rx: 16x-oversampled UART receiver (LSB first) with one-clock done pulse and frame error flag.
// Define UART_RX_PARITY_EN to receive a parity bit after the data bits; otherwise parity_err is held low.
module uart_rx #(
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] rx_dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);
  localparam int SW = (SB_TICK > 16) ? 5 : 4;
  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
  localparam logic [SW-1:0] S_MID  = SW'(7);
  localparam logic [SW-1:0] S_BIT  = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state;
  logic [SW-1:0]   s;
  logic [NW-1:0]   n;
  logic [DBIT-1:0] sh;
  logic            rx_p0;
  logic            rx_s;
  logic            rx_prev;
`ifdef UART_RX_PARITY_EN
  logic            par_bit;
`endif

  // Two-flop synchronizer; resets to the idle (high) line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_p0 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_s  <= rx_p0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      s            <= '0;
      n            <= '0;
      sh           <= '0;
      rx_prev      <= 1'b1;
      rx_dout      <= '0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      rx_prev      <= rx_s;
      case (state)
        // A held-low line after a break never re-triggers: only a fresh 1->0 edge starts a frame
        IDLE: if (rx_prev && !rx_s) begin
          state <= START;
          s     <= '0;
        end
        START: if (s_tick) begin
          if (s == S_MID) begin
            if (!rx_s) begin
              state <= DATA;
              s     <= '0;
              n     <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            s <= s + 1'b1;
          end
        end
        DATA: if (s_tick) begin
          if (s == S_BIT) begin
            s  <= '0;
            sh <= {rx_s, sh[DBIT-1:1]};
            if (n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              n <= n + 1'b1;
            end
          end else begin
            s <= s + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (s_tick) begin
          if (s == S_BIT) begin
            par_bit <= rx_s;
            s       <= '0;
            state   <= STOP;
          end else begin
            s <= s + 1'b1;
          end
        end
`endif
        STOP: if (s_tick) begin
          if (s == S_STOP) begin
            rx_dout      <= sh;
            frame_err    <= ~rx_s;
            rx_done_tick <= 1'b1;
            state        <= IDLE;
`ifdef UART_RX_PARITY_EN
            parity_err   <= ^{sh, par_bit, PARITY_ODD[0]};
`endif
          end else begin
            s <= s + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  // No parity bit is framed in this build, so the flag can never be raised
  assign parity_err = PARITY_ODD[0] & 1'b0;
`endif

endmodule
